// File: rtl/attack_map_collector.sv
// rtl/attack_map_collector.sv - board broadcast and attack-map collection front end
//
// Purpose:
//   Accepts a board over a valid/ready handshake, broadcasts it to the
//   128-instance attack-evaluator array with a one-cycle strobe, waits for a
//   cycle in which every evaluator reports valid, and packs the results into
//   two 64-bit attack maps plus king-in-check flags.  A wait that lasts
//   TIMEOUT cycles aborts with error=1 and zeroed maps.
//
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   board_in / _valid / _ready         incoming position handshake
//   board_out / board_out_valid        broadcast to evaluators (one-cycle strobe)
//   white_attacking / _valid / white_opp_check   white-attack evaluator outputs
//   black_attacking / _valid / black_opp_check   black-attack evaluator outputs
//   white_attack_map, black_attack_map packed attack maps
//   white_in_check, black_in_check     king-in-check flags
//   result_valid / result_ready        result handshake
//   error                              timeout abort, qualified by result_valid
//
// Optional feature (macro ATTACK_POPCOUNT_EN):
//   white_attack_count, black_attack_count - 7-bit population counts of the
//   captured maps, registered and held with the maps.

`timescale 1ns/1ps

`ifndef BOARD_WIDTH
`define BOARD_WIDTH 256
`endif

module attack_map_collector #(
  parameter int TIMEOUT   = 15,
  parameter int CNT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [`BOARD_WIDTH-1:0] board_in,
  input  logic                    board_in_valid,
  output logic                    board_in_ready,
  output logic [`BOARD_WIDTH-1:0] board_out,
  output logic                    board_out_valid,
  input  logic [63:0]             white_attacking,
  input  logic [63:0]             white_attacking_valid,
  input  logic [63:0]             white_opp_check,
  input  logic [63:0]             black_attacking,
  input  logic [63:0]             black_attacking_valid,
  input  logic [63:0]             black_opp_check,
  output logic [63:0]             white_attack_map,
  output logic [63:0]             black_attack_map,
  output logic                    white_in_check,
  output logic                    black_in_check,
`ifdef ATTACK_POPCOUNT_EN
  output logic [6:0]              white_attack_count,
  output logic [6:0]              black_attack_count,
`endif
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    error
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] counter;
  logic                 all_valid;

  // Only a single cycle with all 128 valids high counts; nothing accumulates.
  assign all_valid = (&white_attacking_valid) && (&black_attacking_valid);

`ifdef ATTACK_POPCOUNT_EN
  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 0; i < 64; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      counter          <= '0;
      board_in_ready   <= 1'b0;
      board_out        <= '0;
      board_out_valid  <= 1'b0;
      white_attack_map <= '0;
      black_attack_map <= '0;
      white_in_check   <= 1'b0;
      black_in_check   <= 1'b0;
      result_valid     <= 1'b0;
      error            <= 1'b0;
`ifdef ATTACK_POPCOUNT_EN
      white_attack_count <= '0;
      black_attack_count <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Ready is registered so it stays low for the first cycle after reset release.
          board_in_ready <= 1'b1;
          if (board_in_valid && board_in_ready) begin
            board_out       <= board_in;
            board_out_valid <= 1'b1;
            board_in_ready  <= 1'b0;
            state           <= ISSUE;
          end
        end

        ISSUE: begin
          board_out_valid <= 1'b0;
          counter         <= '0;
          state           <= WAIT;
        end

        WAIT: begin
          counter <= counter + CNT_WIDTH'(1);
          if (all_valid) begin
            white_attack_map <= white_attacking;
            black_attack_map <= black_attacking;
            // White evaluators flag the opponent (black) king, and vice versa.
            black_in_check   <= |white_opp_check;
            white_in_check   <= |black_opp_check;
            error            <= 1'b0;
            result_valid     <= 1'b1;
`ifdef ATTACK_POPCOUNT_EN
            white_attack_count <= popcount64(white_attacking);
            black_attack_count <= popcount64(black_attacking);
`endif
            state            <= DONE;
          end else if (counter == CNT_WIDTH'(TIMEOUT - 1)) begin
            white_attack_map <= '0;
            black_attack_map <= '0;
            black_in_check   <= 1'b0;
            white_in_check   <= 1'b0;
            error            <= 1'b1;
            result_valid     <= 1'b1;
`ifdef ATTACK_POPCOUNT_EN
            white_attack_count <= '0;
            black_attack_count <= '0;
`endif
            state            <= DONE;
          end
        end

        DONE: begin
          if (result_ready) begin
            result_valid   <= 1'b0;
            board_in_ready <= 1'b1;
            state          <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
